// File: rtl/cpu_ext_trace_pll_ctrl_if.sv
// Signal bundle between the CPU-side trace control and the trace PLL lock sequencer.
// The master drives the PLL/trace requests; the slave (the sequencer) drives status.
interface cpu_ext_trace_pll_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             relock_req;
  logic             trace_req;
  logic             pll_areset;
  logic             trace_clk_en;
  logic             trace_reset;
  logic             ready;
  logic             fail;
  logic [3:0]       retry_cnt;
  logic [CNT_W-1:0] unlock_cnt;
  logic [1:0]       state;

  modport master (
    output pll_locked, relock_req, trace_req,
    input  pll_areset, trace_clk_en, trace_reset, ready, fail, retry_cnt, unlock_cnt, state
  );

  modport slave (
    input  pll_locked, relock_req, trace_req,
    output pll_areset, trace_clk_en, trace_reset, ready, fail, retry_cnt, unlock_cnt, state
  );
endinterface

// File: rtl/cpu_ext_trace_pll_ctrl.sv
// Trace 2x PLL reset sequencer and lock monitor: pulses the PLL reset, qualifies a
// synchronized lock, retries on timeout, and gates the trace domain once locked.
//   state     | meaning
//   ST_RESET  | pll_areset held high for RESET_CYCLES edges
//   ST_WAIT   | waiting for LOCK_STABLE_CYCLES consecutive lock_s, bounded by timeout
//   ST_RUN    | locked; trace domain out of reset, clock enable follows trace_req
//   ST_FAIL   | retry budget exhausted; idle until relock_req
module cpu_ext_trace_pll_ctrl #(
  parameter int RESET_CYCLES        = 8,
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 8
) (
  input logic                     clk,
  input logic                     reset,
  cpu_ext_trace_pll_ctrl_if.slave ctrl_if
);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]    stable_q, stable_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [3:0]       retry_q, retry_d;
  logic [CNT_W-1:0] unlock_q, unlock_d;
  logic             sync1_q, lock_s_q;
  logic             pll_areset_q, pll_areset_d;
  logic             trace_reset_q, trace_reset_d;
  logic             trace_clk_en_q, trace_clk_en_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RESET;
      rst_cnt_q      <= '0;
      stable_q       <= '0;
      tmo_q          <= '0;
      retry_q        <= '0;
      unlock_q       <= '0;
      sync1_q        <= 1'b0;
      lock_s_q       <= 1'b0;
      pll_areset_q   <= 1'b1;
      trace_reset_q  <= 1'b1;
      trace_clk_en_q <= 1'b0;
      ready_q        <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      stable_q       <= stable_d;
      tmo_q          <= tmo_d;
      retry_q        <= retry_d;
      unlock_q       <= unlock_d;
      sync1_q        <= ctrl_if.pll_locked;
      lock_s_q       <= sync1_q;
      pll_areset_q   <= pll_areset_d;
      trace_reset_q  <= trace_reset_d;
      trace_clk_en_q <= trace_clk_en_d;
      ready_q        <= ready_d;
      fail_q         <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stable_d  = stable_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    unlock_d  = unlock_q;
    case (state_q)
      ST_RESET: begin
        rst_cnt_d = rst_cnt_q + RW'(1);
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
          state_d  = ST_WAIT;
          stable_d = '0;
          tmo_d    = '0;
        end
      end
      ST_WAIT: begin
        tmo_d    = tmo_q + TW'(1);
        stable_d = lock_s_q ? stable_q + SW'(1) : '0;
        // Success beats timeout, and both beat a relock request on the same edge.
        if (lock_s_q && (stable_q == SW'(LOCK_STABLE_CYCLES - 1))) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else if (tmo_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (retry_q < 4'(MAX_RETRIES)) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (ctrl_if.relock_req) begin
          state_d = ST_RESET;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          if (unlock_q != '1) unlock_d = unlock_q + CNT_W'(1);
          state_d = ST_RESET;
        end else if (ctrl_if.relock_req) begin
          state_d = ST_RESET;
        end
      end
      default: begin
        if (ctrl_if.relock_req) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
    endcase
    if ((state_d == ST_RESET) && (state_q != ST_RESET)) rst_cnt_d = '0;

    // Outputs are registered from the next state so they change with state_q.
    pll_areset_d   = (state_d == ST_RESET);
    ready_d        = (state_d == ST_RUN);
    fail_d         = (state_d == ST_FAIL);
    trace_reset_d  = (state_d != ST_RUN);
    trace_clk_en_d = (state_d == ST_RUN) && ctrl_if.trace_req;
  end

  assign ctrl_if.state        = state_q;
  assign ctrl_if.pll_areset   = pll_areset_q;
  assign ctrl_if.trace_reset  = trace_reset_q;
  assign ctrl_if.trace_clk_en = trace_clk_en_q;
  assign ctrl_if.ready        = ready_q;
  assign ctrl_if.fail         = fail_q;
  assign ctrl_if.retry_cnt    = retry_q;
  assign ctrl_if.unlock_cnt   = unlock_q;
endmodule

// File: tb/tb_cpu_ext_trace_pll_ctrl.sv
// Directed bench for the trace PLL sequencer: a vector table for the default
// instance plus hand sequences for glitches, timeouts, async reset and saturation.
module tb_cpu_ext_trace_pll_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_ext_trace_pll_ctrl_if #(.CNT_W(8)) if0 ();
  cpu_ext_trace_pll_ctrl_if #(.CNT_W(2)) if1 ();

  cpu_ext_trace_pll_ctrl dut0 (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (if0)
  );

  cpu_ext_trace_pll_ctrl #(
    .RESET_CYCLES        (2),
    .LOCK_STABLE_CYCLES  (1),
    .LOCK_TIMEOUT_CYCLES (8),
    .MAX_RETRIES         (1),
    .CNT_W               (2)
  ) dut1 (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (if1)
  );

  typedef struct {
    logic       locked;
    logic       relock;
    logic       treq;
    int         n;
    logic [1:0] st;
    logic       ar, ce, tr, rd, fl;
    logic [3:0] rc;
    logic [7:0] uc;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_RST = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2, S_FAIL = 2'd3;

  function automatic vec_t mk(logic locked, logic relock, logic treq, int n, logic [1:0] st,
                              logic ar, logic ce, logic tr, logic rd, logic fl,
                              logic [3:0] rc, logic [7:0] uc);
    vec_t v;
    v.locked = locked; v.relock = relock; v.treq = treq; v.n = n; v.st = st;
    v.ar = ar; v.ce = ce; v.tr = tr; v.rd = rd; v.fl = fl; v.rc = rc; v.uc = uc;
    return v;
  endfunction

  // {state, pll_areset, trace_clk_en, trace_reset, ready, fail, retry_cnt, unlock_cnt}
  function automatic logic [18:0] obs0();
    return {if0.state, if0.pll_areset, if0.trace_clk_en, if0.trace_reset, if0.ready,
            if0.fail, if0.retry_cnt, if0.unlock_cnt};
  endfunction

  function automatic logic [18:0] pack(logic [1:0] st, logic ar, logic ce, logic tr, logic rd,
                                       logic fl, logic [3:0] rc, logic [7:0] uc);
    return {st, ar, ce, tr, rd, fl, rc, uc};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready1(string name);
    int k = 0;
    while (!if1.ready && k < 100) begin
      tick(1);
      k++;
    end
    check(name, 32'(if1.ready), 32'd1);
  endtask

  initial begin
    if0.pll_locked = 1'b1; if0.relock_req = 1'b0; if0.trace_req = 1'b0;
    if1.pll_locked = 1'b0; if1.relock_req = 1'b0; if1.trace_req = 1'b0;

    // locked, relock, treq, edges | state, areset, clk_en, trace_reset, ready, fail, retry, unlock
    tbl.push_back(mk(1, 0, 0,  7, S_RST,  1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  1, S_WAIT, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 15, S_WAIT, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  1, S_RUN,  0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  1, S_RUN,  0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  1, S_RUN,  0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  1, S_RUN,  0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  2, S_RUN,  0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  1, S_RST,  1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1,  8, S_WAIT, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 15, S_WAIT, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1,  1, S_RUN,  0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1,  1, S_RST,  1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0,  8, S_WAIT, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 16, S_RUN,  0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0,  1, S_RST,  1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0,  8, S_WAIT, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0,  1, S_RST,  1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0,  8, S_WAIT, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 16, S_RUN,  0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  2, S_RUN,  0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  1, S_RST,  1, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 24, S_RUN,  0, 0, 0, 1, 0, 0, 2));

    tick(3);
    check("reset_values", 32'(obs0()), 32'(pack(S_RST, 1, 0, 1, 0, 0, 0, 0)));
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      if0.pll_locked = tbl[i].locked;
      if0.relock_req = tbl[i].relock;
      if0.trace_req  = tbl[i].treq;
      tick(tbl[i].n);
      check($sformatf("vec%0d", i), 32'(obs0()),
            32'(pack(tbl[i].st, tbl[i].ar, tbl[i].ce, tbl[i].tr, tbl[i].rd, tbl[i].fl,
                     tbl[i].rc, tbl[i].uc)));
    end
    if0.relock_req = 1'b0;

    // One-cycle dropout in WAIT must restart the stability count.
    if0.pll_locked = 1'b0; if0.relock_req = 1'b1;
    tick(1);
    if0.relock_req = 1'b0;
    check("glitch_enter_reset", 32'(obs0()), 32'(pack(S_RST, 1, 0, 1, 0, 0, 0, 2)));
    tick(8);
    check("glitch_wait", 32'(if0.state), 32'(S_WAIT));
    if0.pll_locked = 1'b1;
    tick(10);
    if0.pll_locked = 1'b0;
    tick(1);
    if0.pll_locked = 1'b1;
    tick(17);
    check("glitch_still_wait", 32'(if0.state), 32'(S_WAIT));
    tick(1);
    check("glitch_run", 32'(obs0()), 32'(pack(S_RUN, 0, 0, 0, 1, 0, 0, 2)));

    // Asynchronous reset in the middle of WAIT_LOCK, between edges.
    if0.relock_req = 1'b1;
    tick(1);
    if0.relock_req = 1'b0;
    tick(8 + 3);
    check("pre_async_wait", 32'(if0.state), 32'(S_WAIT));
    #3 reset = 1'b1;
    #1;
    check("async_reset", 32'(obs0()), 32'(pack(S_RST, 1, 0, 1, 0, 0, 0, 0)));

    // No lock at all: three retries then FAIL.
    if0.pll_locked = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1031);
    check("nolock_1031", 32'(obs0()), 32'(pack(S_WAIT, 0, 0, 1, 0, 0, 0, 0)));
    tick(1);
    check("nolock_1032", 32'(obs0()), 32'(pack(S_RST, 1, 0, 1, 0, 0, 1, 0)));
    tick(1032);
    check("nolock_2064", 32'(obs0()), 32'(pack(S_RST, 1, 0, 1, 0, 0, 2, 0)));
    tick(1032);
    check("nolock_3096", 32'(obs0()), 32'(pack(S_RST, 1, 0, 1, 0, 0, 3, 0)));
    tick(1031);
    check("nolock_4127", 32'(obs0()), 32'(pack(S_WAIT, 0, 0, 1, 0, 0, 3, 0)));
    tick(1);
    check("nolock_4128", 32'(obs0()), 32'(pack(S_FAIL, 0, 0, 1, 0, 1, 3, 0)));
    tick(20);
    check("fail_hold", 32'(obs0()), 32'(pack(S_FAIL, 0, 0, 1, 0, 1, 3, 0)));
    if0.relock_req = 1'b1;
    tick(1);
    if0.relock_req = 1'b0;
    check("fail_recover", 32'(obs0()), 32'(pack(S_RST, 1, 0, 1, 0, 0, 0, 0)));

    // Small instance: recover from FAIL, then saturate a 2-bit unlock counter.
    check("dut1_fail", 32'({if1.state, if1.fail}), 32'({S_FAIL, 1'b1}));
    if1.pll_locked = 1'b1;
    if1.relock_req = 1'b1;
    tick(1);
    if1.relock_req = 1'b0;
    wait_ready1("dut1_ready_first");
    for (int i = 1; i <= 5; i++) begin
      logic [1:0] exp_uc;
      exp_uc = (i > 3) ? 2'd3 : 2'(i);
      if1.pll_locked = 1'b0;
      tick(3);
      check($sformatf("dut1_loss%0d", i), 32'({if1.state, if1.unlock_cnt}), 32'({S_RST, exp_uc}));
      if1.pll_locked = 1'b1;
      wait_ready1($sformatf("dut1_ready%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
